// File: rtl/life_seq.sv
// -----------------------------------------------------------------------------
// life_seq -- generation sequencer and host-access controller for the Life
// PE array.
//
// Takes host requests on a valid/ready port. It drives the array-wide command
// bus, the one-hot row/column selects, the write data and the generation
// trigger. It runs generations at a programmable rate and supports
// single-stepping. It flags a board that produced no change in its last
// generation as stable.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   req_valid/req_ready  host handshake (accept when both high)
//   req_op               0 NOP, 1 WRITE, 2 READ, 3 STEP, 4 RUN, 5 STOP, 6-7 NOP
//   req_row/req_col      target cell; out-of-range values select nothing
//   req_wdata            cell write data
//   period               cycles between triggers in RUN (0 behaves as 1)
//   auto_stop            leave RUN on a generation with no activity
//   arr_active           OR of all PE active flags
//   arr_rdata            OR of all PE state outputs
//   cmd, rsel, csel      array command bus and one-hot selects
//   state_in             array write data
//   trigger              generation strobe
//   done                 one-cycle completion pulse (not for RUN entry)
//   rdata                last READ result, held until the next READ capture
//   running              high while in RUN
//   stable               last generation produced no change
//   gen_count            generations executed, wraps at 2^32
// -----------------------------------------------------------------------------

`ifndef PE_CMD_BITS
`define PE_CMD_BITS 2
`endif
`ifndef PE_STATE_BITS
`define PE_STATE_BITS 1
`endif
`ifndef PE_CMD_NOP
`define PE_CMD_NOP 0
`endif
`ifndef PE_CMD_PROCESS
`define PE_CMD_PROCESS 1
`endif
`ifndef PE_CMD_WRITE
`define PE_CMD_WRITE 2
`endif
`ifndef PE_CMD_READ
`define PE_CMD_READ 3
`endif

module life_seq #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int CMD_BITS   = `PE_CMD_BITS,
    parameter int STATE_BITS = `PE_STATE_BITS,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [RW-1:0]         req_row,
    input  logic [CW-1:0]         req_col,
    input  logic [STATE_BITS-1:0] req_wdata,
    input  logic [15:0]           period,
    input  logic                  auto_stop,
    input  logic                  arr_active,
    input  logic [STATE_BITS-1:0] arr_rdata,
    output logic [CMD_BITS-1:0]   cmd,
    output logic [ROWS-1:0]       rsel,
    output logic [COLS-1:0]       csel,
    output logic [STATE_BITS-1:0] state_in,
    output logic                  trigger,
    output logic                  done,
    output logic [STATE_BITS-1:0] rdata,
    output logic                  running,
    output logic                  stable,
    output logic [31:0]           gen_count
);

    localparam logic [CMD_BITS-1:0] CMD_NOP     = CMD_BITS'(`PE_CMD_NOP);
    localparam logic [CMD_BITS-1:0] CMD_PROCESS = CMD_BITS'(`PE_CMD_PROCESS);
    localparam logic [CMD_BITS-1:0] CMD_WRITE   = CMD_BITS'(`PE_CMD_WRITE);
    localparam logic [CMD_BITS-1:0] CMD_READ    = CMD_BITS'(`PE_CMD_READ);

    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_RUN   = 3'd4;
    localparam logic [2:0] OP_STOP  = 3'd5;

    localparam logic [RW:0] ROWS_L = (RW+1)'(ROWS);
    localparam logic [CW:0] COLS_L = (CW+1)'(COLS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_CMD  = 3'd2,
        RD_WAIT = 3'd3,
        RD_CAP  = 3'd4,
        STEP    = 3'd5,
        RUN     = 3'd6,
        ACK     = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [15:0]             r_cnt;
    logic [15:0]             w_cnt_next;
    logic [15:0]             w_reload;
    logic [RW-1:0]           r_row;
    logic [CW-1:0]           r_col;
    logic                    r_ready;
    logic                    r_trigger;
    logic                    w_trigger_next;
    logic [CMD_BITS-1:0]     r_cmd;
    logic [CMD_BITS-1:0]     w_cmd_next;
    logic [ROWS-1:0]         r_rsel;
    logic [ROWS-1:0]         w_rsel_next;
    logic [COLS-1:0]         r_csel;
    logic [COLS-1:0]         w_csel_next;
    logic [STATE_BITS-1:0]   r_state_in;
    logic [STATE_BITS-1:0]   w_state_in_next;
    logic                    r_done;
    logic [STATE_BITS-1:0]   r_rdata;
    logic                    r_running;
    logic                    r_stable;
    logic [31:0]             r_gen_count;
    logic                    w_accept;
    logic                    w_stop_acc;
    logic                    w_sel_en;
    logic                    w_cell_ok;
    logic                    w_gen_done;

    // A host accept in IDLE, and a STOP accept while running.
    assign w_accept   = (r_state == IDLE) && req_valid && r_ready;
    assign w_stop_acc = (r_state == RUN) && req_valid && (req_op == OP_STOP);

    // Counter reload value: max(period,1)-1, sampled at every reload.
    assign w_reload = (period == 16'd0) ? 16'd0 : (period - 16'd1);

    // A generation is counted on every trigger cycle except one that is
    // cancelled by a STOP accepted in the same cycle.
    assign w_gen_done = r_trigger && !w_stop_acc;

    // Out-of-range cells read back as 0 regardless of the array bus.
    assign w_cell_ok = ({1'b0, r_row} < ROWS_L) && ({1'b0, r_col} < COLS_L);

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (req_op)
                        OP_WRITE: w_state_next = WR;
                        OP_READ:  w_state_next = RD_CMD;
                        OP_STEP:  w_state_next = STEP;
                        OP_RUN: begin
                            w_state_next = RUN;
                            w_cnt_next   = w_reload;
                        end
                        default:  w_state_next = ACK;
                    endcase
                end
            end
            WR:      w_state_next = ACK;
            RD_CMD:  w_state_next = RD_WAIT;
            RD_WAIT: w_state_next = RD_CAP;
            RD_CAP:  w_state_next = ACK;
            STEP:    w_state_next = ACK;
            RUN: begin
                if (w_stop_acc || (r_trigger && auto_stop && !arr_active)) begin
                    w_state_next = ACK;
                end else begin
                    w_cnt_next = (r_cnt == 16'd0) ? w_reload : (r_cnt - 16'd1);
                end
            end
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered. That way the
    // array sees a request in the cycle right after it is accepted. WR and
    // RD_CMD are only entered straight from an IDLE accept, so the selects
    // and write data come from the request inputs of that accept cycle.
    always_comb begin
        w_cmd_next      = CMD_NOP;
        w_sel_en        = 1'b0;
        w_state_in_next = '0;
        case (w_state_next)
            WR: begin
                w_cmd_next      = CMD_WRITE;
                w_sel_en        = 1'b1;
                w_state_in_next = req_wdata;
            end
            RD_CMD: begin
                w_cmd_next = CMD_READ;
                w_sel_en   = 1'b1;
            end
            STEP, RUN: w_cmd_next = CMD_PROCESS;
            default:   w_cmd_next = CMD_NOP;
        endcase
        w_trigger_next = (w_state_next == STEP) ||
                         ((w_state_next == RUN) && (w_cnt_next == 16'd0));
    end

    // One-hot decoders; an out-of-range index matches no bit.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_rsel
            assign w_rsel_next[gi] = w_sel_en && (req_row == RW'(gi));
        end
        for (gi = 0; gi < COLS; gi++) begin : g_csel
            assign w_csel_next[gi] = w_sel_en && (req_col == CW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 16'd0;
            r_row       <= '0;
            r_col       <= '0;
            r_ready     <= 1'b0;
            r_trigger   <= 1'b0;
            r_cmd       <= CMD_NOP;
            r_rsel      <= '0;
            r_csel      <= '0;
            r_state_in  <= '0;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_running   <= 1'b0;
            r_stable    <= 1'b0;
            r_gen_count <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_ready    <= (w_state_next == IDLE);
            r_trigger  <= w_trigger_next;
            r_cmd      <= w_cmd_next;
            r_rsel     <= w_rsel_next;
            r_csel     <= w_csel_next;
            r_state_in <= w_state_in_next;
            r_done     <= (w_state_next == ACK);
            r_running  <= (w_state_next == RUN);
            if (w_accept) begin
                r_row <= req_row;
                r_col <= req_col;
            end
            if (r_state == RD_CAP) begin
                r_rdata <= w_cell_ok ? arr_rdata : '0;
            end
            if (w_gen_done) begin
                r_gen_count <= r_gen_count + 32'd1;
                r_stable    <= !arr_active;
            end
        end
    end

    // In RUN the port is ready only for STOP. That readiness, and the
    // masking of a trigger cancelled by that STOP, must react within the
    // request cycle, so these two outputs carry a small combinational term.
    assign req_ready = r_ready || ((r_state == RUN) && (req_op == OP_STOP));
    assign trigger   = r_trigger && !w_stop_acc;

    assign cmd       = r_cmd;
    assign rsel      = r_rsel;
    assign csel      = r_csel;
    assign state_in  = r_state_in;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign running   = r_running;
    assign stable    = r_stable;
    assign gen_count = r_gen_count;

endmodule

// File: tb/tb_life_seq.sv
// -----------------------------------------------------------------------------
// tb_life_seq -- directed self-checking bench for life_seq.
// A 6x8 array is used so that an out-of-range row (7) is representable on the
// 3-bit row port. A tiny cell memory stands in for the PE array. It stores
// WRITEs and registers the selected cell on READ, holding it otherwise.
// Activity is driven directly to mimic blinker / block / glider boards.
// -----------------------------------------------------------------------------
module tb_life_seq;

    localparam int ROWS = 6;
    localparam int COLS = 8;

    localparam logic [1:0] C_NOP = 2'd0;
    localparam logic [1:0] C_PRO = 2'd1;
    localparam logic [1:0] C_WR  = 2'd2;
    localparam logic [1:0] C_RD  = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [2:0]  req_row = 3'd0;
    logic [2:0]  req_col = 3'd0;
    logic [0:0]  req_wdata = 1'b0;
    logic [15:0] period = 16'd0;
    logic        auto_stop = 1'b0;
    logic        arr_active = 1'b0;
    logic [0:0]  arr_rdata;
    logic [1:0]  cmd;
    logic [ROWS-1:0] rsel;
    logic [COLS-1:0] csel;
    logic [0:0]  state_in;
    logic        trigger;
    logic        done;
    logic [0:0]  rdata;
    logic        running;
    logic        stable;
    logic [31:0] gen_count;

    int n_checks = 0;
    int n_errors = 0;

    life_seq #(
        .ROWS(ROWS), .COLS(COLS), .CMD_BITS(2), .STATE_BITS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .period(period), .auto_stop(auto_stop),
        .arr_active(arr_active), .arr_rdata(arr_rdata),
        .cmd(cmd), .rsel(rsel), .csel(csel), .state_in(state_in),
        .trigger(trigger), .done(done), .rdata(rdata),
        .running(running), .stable(stable), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    // Stand-in cell array.
    logic mem [ROWS][COLS];
    logic r_out = 1'b0;
    assign arr_rdata = r_out;

    always @(posedge clk) begin
        if (cmd == C_WR) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    if (rsel[i] && csel[j]) mem[i][j] <= state_in[0];
        end
        if (cmd == C_RD) begin
            logic v;
            v = 1'b0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    if (rsel[i] && csel[j]) v = v | mem[i][j];
            r_out <= v;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted. On return the bench is
    // 1 time unit into cycle t+1.
    task automatic issue(input string name, input logic [2:0] op,
                         input logic [2:0] row, input logic [2:0] col,
                         input logic wd);
        int n;
        req_op = op; req_row = row; req_col = col; req_wdata = wd;
        req_valid = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) check_val({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
        $display("txn %s op=%0d row=%0d col=%0d wdata=%0d", name, op, row, col, wd);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                mem[i][j] = 1'b0;

        // Reset state, sampled while reset is still held.
        tick(); tick();
        check_val("rst_cmd", 32'(cmd), 32'(C_NOP));
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_gen", gen_count, 32'd0);
        check_val("rst_run", 32'(running), 32'd0);
        rst = 1'b0;
        tick();
        check_val("idle_ready", 32'(req_ready), 32'd1);

        // WRITE (2,5)=1
        issue("WRITE", 3'd1, 3'd2, 3'd5, 1'b1);
        check_val("wr_cmd", 32'(cmd), 32'(C_WR));
        check_val("wr_rsel", 32'(rsel), 32'h04);
        check_val("wr_csel", 32'(csel), 32'h20);
        check_val("wr_data", 32'(state_in), 32'd1);
        check_val("wr_done_t1", 32'(done), 32'd0);
        tick();
        check_val("wr_done_t2", 32'(done), 32'd1);
        check_val("wr_ack_cmd", 32'(cmd), 32'(C_NOP));
        check_val("wr_ack_rsel", 32'(rsel), 32'd0);
        tick();

        // READ (2,5) -> 1 with done at t+4
        issue("READ", 3'd2, 3'd2, 3'd5, 1'b0);
        check_val("rd_cmd", 32'(cmd), 32'(C_RD));
        check_val("rd_rsel", 32'(rsel), 32'h04);
        tick();
        check_val("rd_done_t2", 32'(done), 32'd0);
        tick();
        check_val("rd_done_t3", 32'(done), 32'd0);
        tick();
        check_val("rd_done_t4", 32'(done), 32'd1);
        check_val("rd_data", 32'(rdata), 32'd1);
        tick();
        check_val("rd_hold", 32'(rdata), 32'd1);

        // READ row 7 on a 6-row array
        issue("READ_OOR", 3'd2, 3'd7, 3'd5, 1'b0);
        check_val("oor_cmd", 32'(cmd), 32'(C_RD));
        check_val("oor_rsel", 32'(rsel), 32'd0);
        check_val("oor_csel", 32'(csel), 32'h20);
        tick(); tick(); tick();
        check_val("oor_done", 32'(done), 32'd1);
        check_val("oor_rdata", 32'(rdata), 32'd0);
        tick();

        // NOP and reserved op 6 complete at t+1
        issue("NOP", 3'd0, 3'd0, 3'd0, 1'b0);
        check_val("nop_done", 32'(done), 32'd1);
        tick();
        issue("OP6", 3'd6, 3'd0, 3'd0, 1'b0);
        check_val("op6_done", 32'(done), 32'd1);
        check_val("op6_cmd", 32'(cmd), 32'(C_NOP));
        tick();

        // Blinker: RUN period 3, triggers at t+3, t+6, t+9
        arr_active = 1'b1; auto_stop = 1'b0; period = 16'd3;
        issue("RUN_P3", 3'd4, 3'd0, 3'd0, 1'b0);
        check_val("run_running", 32'(running), 32'd1);
        check_val("run_cmd", 32'(cmd), 32'(C_PRO));
        check_val("run_rsel", 32'(rsel), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            check_val($sformatf("run_trig_t%0d", k), 32'(trigger),
                      (k % 3 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        check_val("run_gen3", gen_count, 32'd3);
        check_val("run_stable", 32'(stable), 32'd0);
        req_op = 3'd1; req_valid = 1'b1;
        #1;
        check_val("run_stall_wr", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        issue("STOP", 3'd5, 3'd0, 3'd0, 1'b0);
        check_val("stop_done", 32'(done), 32'd1);
        check_val("stop_running", 32'(running), 32'd0);
        check_val("stop_cmd", 32'(cmd), 32'(C_NOP));
        for (int k = 0; k < 5; k++) begin
            check_val("stop_no_trig", 32'(trigger), 32'd0);
            tick();
        end
        check_val("stop_gen", gen_count, 32'd3);

        // Block: auto_stop with period 1
        arr_active = 1'b0; auto_stop = 1'b1; period = 16'd1;
        issue("RUN_BLOCK", 3'd4, 3'd0, 3'd0, 1'b0);
        check_val("blk_trig", 32'(trigger), 32'd1);
        tick();
        check_val("blk_done", 32'(done), 32'd1);
        check_val("blk_stable", 32'(stable), 32'd1);
        check_val("blk_gen", gen_count, 32'd4);
        check_val("blk_running", 32'(running), 32'd0);
        tick();
        check_val("blk_idle_ready", 32'(req_ready), 32'd1);

        // Glider: two single steps
        arr_active = 1'b1; auto_stop = 1'b0;
        for (int s = 0; s < 2; s++) begin
            issue("STEP", 3'd3, 3'd0, 3'd0, 1'b0);
            check_val("step_trig", 32'(trigger), 32'd1);
            check_val("step_cmd", 32'(cmd), 32'(C_PRO));
            tick();
            check_val("step_trig_off", 32'(trigger), 32'd0);
            check_val("step_done", 32'(done), 32'd1);
            tick();
        end
        check_val("step_gen", gen_count, 32'd6);
        check_val("step_stable", 32'(stable), 32'd0);

        // Period 0: trigger every cycle; STOP in a trigger cycle cancels it
        period = 16'd0;
        issue("RUN_P0", 3'd4, 3'd0, 3'd0, 1'b0);
        check_val("p0_trig1", 32'(trigger), 32'd1);
        tick();
        check_val("p0_trig2", 32'(trigger), 32'd1);
        check_val("p0_gen7", gen_count, 32'd7);
        tick();
        req_op = 3'd5; req_valid = 1'b1;
        #1;
        $display("txn STOP_ON_TRIGGER op=5");
        check_val("p0_stop_ready", 32'(req_ready), 32'd1);
        check_val("p0_trig_cancel", 32'(trigger), 32'd0);
        tick();
        req_valid = 1'b0;
        check_val("p0_stop_done", 32'(done), 32'd1);
        check_val("p0_gen8", gen_count, 32'd8);
        tick();

        // Reset during RD_WAIT
        issue("READ_PRE", 3'd2, 3'd2, 3'd5, 1'b0);
        tick(); tick(); tick(); tick();
        check_val("pre_rdata", 32'(rdata), 32'd1);
        issue("READ_ABORT", 3'd2, 3'd2, 3'd5, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check_val("abort_cmd", 32'(cmd), 32'(C_NOP));
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_rdata", 32'(rdata), 32'd0);
        check_val("abort_gen", gen_count, 32'd0);
        rst = 1'b0;
        tick();
        check_val("abort_ready", 32'(req_ready), 32'd1);
        check_val("abort_no_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
